// File: rtl/controller_pkg.sv
// Shared constants for the NES controller poller: button bit positions,
// FSM state encoding and the default controller half-period.
package controller_pkg;

    localparam int BTN_A      = 7;
    localparam int BTN_B      = 6;
    localparam int BTN_SELECT = 5;
    localparam int BTN_START  = 4;
    localparam int BTN_UP     = 3;
    localparam int BTN_DOWN   = 2;
    localparam int BTN_LEFT   = 1;
    localparam int BTN_RIGHT  = 0;

    localparam int HALF_PERIOD_DEFAULT = 76;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LATCH = 2'd1,
        LOW   = 2'd2,
        HIGH  = 2'd3
    } ctrl_state_e;

endpackage

// File: rtl/controller_interface_m_if.sv
// CPU-side bus port of the controller block: select/address/write in, button byte out.
interface controller_interface_m_if;

    logic       SELECT_controller;
    logic       address_lsb;
    logic       write_enable;
    logic [7:0] data_out;
    logic       data_enable;

    modport master (
        output SELECT_controller,
        output address_lsb,
        output write_enable,
        input  data_out,
        input  data_enable
    );

    modport slave (
        input  SELECT_controller,
        input  address_lsb,
        input  write_enable,
        output data_out,
        output data_enable
    );

endinterface

// File: rtl/controller_phase_timer_m.sv
// Loadable down-counter; phase_done is high while the count sits at zero.
module controller_phase_timer_m (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic       phase_done
);

    logic [7:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load)
            count_d = load_val;
        else if (count_q != '0)
            count_d = count_q - 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign phase_done = (count_q == '0);

endmodule

// File: rtl/controller_interface_m.sv
// Polls two NES serial controllers once per frame and serves the committed
// button bytes to the CPU bus.
module controller_interface_m
    import controller_pkg::*;
#(
    parameter int HALF_PERIOD = HALF_PERIOD_DEFAULT
) (
    input  logic       clk_12_5875,
    input  logic       rst_B,
    input  logic       poll,
    input  logic [1:0] ctrl_data,
    output logic       ctrl_latch,
    output logic       ctrl_clock,
    output logic       busy,
    controller_interface_m_if.slave bus
);

    localparam logic [7:0] PHASE_LOAD = 8'(HALF_PERIOD - 1);

    ctrl_state_e state_q, state_d;
    logic [2:0]  i_q, i_d;
    logic [7:0]  sh0_q, sh0_d, sh1_q, sh1_d;
    logic [7:0]  vis0_q, vis0_d, vis1_q, vis1_d;
    logic        latch_q, clock_q, busy_q;
    logic        load, phase_done;

    controller_phase_timer_m u_timer (
        .clk        (clk_12_5875),
        .rst_n      (rst_B),
        .load       (load),
        .load_val   (PHASE_LOAD),
        .phase_done (phase_done)
    );

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        sh0_d   = sh0_q;
        sh1_d   = sh1_q;
        vis0_d  = vis0_q;
        vis1_d  = vis1_q;
        load    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (poll) begin
                    sh0_d   = '0;
                    sh1_d   = '0;
                    i_d     = '0;
                    load    = 1'b1;
                    state_d = LATCH;
                end
            end
            // Latch spans two half-periods so the 8-bit timer covers any
            // HALF_PERIOD; i[0] marks the second half and is cleared on exit.
            LATCH: begin
                if (phase_done) begin
                    load = 1'b1;
                    if (!i_q[0]) begin
                        i_d = 3'd1;
                    end else begin
                        i_d     = '0;
                        state_d = LOW;
                    end
                end
            end
            LOW: begin
                if (phase_done) begin
                    sh0_d = {sh0_q[6:0], ~ctrl_data[0]};
                    sh1_d = {sh1_q[6:0], ~ctrl_data[1]};
                    if (i_q == 3'd7) begin
                        vis0_d  = sh0_d;
                        vis1_d  = sh1_d;
                        state_d = IDLE;
                    end else begin
                        load    = 1'b1;
                        state_d = HIGH;
                    end
                end
            end
            HIGH: begin
                if (phase_done) begin
                    i_d     = i_q + 3'd1;
                    load    = 1'b1;
                    state_d = LOW;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_12_5875 or negedge rst_B) begin
        if (!rst_B) begin
            state_q <= IDLE;
            i_q     <= '0;
            sh0_q   <= '0;
            sh1_q   <= '0;
            vis0_q  <= '0;
            vis1_q  <= '0;
            latch_q <= 1'b0;
            clock_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            sh0_q   <= sh0_d;
            sh1_q   <= sh1_d;
            vis0_q  <= vis0_d;
            vis1_q  <= vis1_d;
            latch_q <= (state_d == LATCH);
            clock_q <= (state_d == HIGH);
            busy_q  <= (state_d != IDLE);
        end
    end

    assign ctrl_latch = latch_q;
    assign ctrl_clock = clock_q;
    assign busy       = busy_q;

    assign bus.data_enable = bus.SELECT_controller & ~bus.write_enable;
    assign bus.data_out    = bus.address_lsb ? vis1_q : vis0_q;

endmodule
